// File: rtl/queue_to_umi_rx.sv
// queue_to_umi_rx: reassembles switchboard flits into UMI transactions through a double buffer
module queue_to_umi_rx #(
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int FW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data,
    output logic [AW-1:0] srcaddr,
    output logic [AW-1:0] dstaddr,
    output logic [CW-1:0] cmd,
    output logic          valid,
    input  logic          ready,
    output logic [7:0]    err_count
);
    localparam int TW = DW + 2 * AW + CW;
    localparam int NFLIT = (TW + FW - 1) / FW;
    localparam int IW = $clog2(NFLIT);
    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] DISCARD = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [TW-1:0] asm_q;
    logic [TW-1:0] out_q;
    logic          accept;
    logic          at_end;
    logic          xfer;

    assign in_ready = state != HOLD;
    assign accept   = in_valid && in_ready;
    assign at_end   = idx == IW'(NFLIT - 1);
    assign xfer     = state == HOLD && (!valid || ready);

    assign cmd     = out_q[CW-1:0];
    assign dstaddr = out_q[CW +: AW];
    assign srcaddr = out_q[CW + AW +: AW];
    assign data    = out_q[CW + 2 * AW +: DW];

    // Framing FSM: short packets (last before the final flit) and long packets (no last on it) are errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= '0;
            valid     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (state == COLLECT && accept) begin
                idx <= (at_end || in_last) ? '0 : idx + 1'b1;
                if (at_end) state <= in_last ? HOLD : DISCARD;
                if (at_end != in_last) err_count <= err_count + {7'd0, err_count != 8'hFF};
            end
            if (state == DISCARD && accept && in_last) state <= COLLECT;
            if (xfer) state <= COLLECT;
            valid <= xfer || (valid && !ready);
        end
    end

    // Assembly register: flit k lands at bits [k*FW +: FW]; bits of the final flit beyond TW are dropped
    always_ff @(posedge clk) begin
        if (state == COLLECT && accept)
            for (int b = 0; b < TW; b++)
                if (idx == IW'(b / FW)) asm_q[b] <= in_data[b % FW];
    end

    // Output register: loaded only on transfer, so fields stay frozen while the sink stalls
    always_ff @(posedge clk) begin
        if (xfer) out_q <= asm_q;
    end
endmodule

// File: tb/tb_queue_to_umi_rx.sv
// tb_queue_to_umi_rx: table vectors, directed corner sequences and a randomized packet-level model
module tb_queue_to_umi_rx;
    localparam int DW = 256;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int FW = 128;
    localparam int TW = DW + 2 * AW + CW;
    localparam int NF = (TW + FW - 1) / FW;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data;
    logic [AW-1:0] srcaddr;
    logic [AW-1:0] dstaddr;
    logic [CW-1:0] cmd;
    logic          valid;
    logic          ready;
    logic [7:0]    err_count;

    queue_to_umi_rx #(.DW(DW), .AW(AW), .CW(CW), .FW(FW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .data(data), .srcaddr(srcaddr), .dstaddr(dstaddr), .cmd(cmd),
        .valid(valid), .ready(ready), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
        int            nflit;
        bit            emit;
        logic [7:0]    err;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            lowcnt = 0;
    bit            mon_en = 1'b0;
    bit            rnd_ready = 1'b0;
    logic [TW-1:0] expq[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake on the UMI port must match the next expected transaction
    always @(negedge clk) begin
        if (!rst && !in_ready) lowcnt++;
        if (mon_en && !rst && valid && ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_txn: got %0h expected none", {data, srcaddr, dstaddr, cmd});
            end else begin
                logic [TW-1:0] e;
                e = expq.pop_front();
                if ({data, srcaddr, dstaddr, cmd} !== e) begin
                    errors++;
                    $display("FAIL txn: got %0h expected %0h", {data, srcaddr, dstaddr, cmd}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) ready = ($urandom_range(3) != 0);
    endtask

    task automatic send_flit(input logic [FW-1:0] d, input logic l);
        logic rdy;
        int   n;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL flit_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end
    endtask

    task automatic send_pkt(input logic [511:0] pk, input int n, input int gap_max);
        logic [FW-1:0] d;
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max)) tick();
            end
            d = k < NF ? pk[k*FW +: FW] : {$urandom, $urandom, $urandom, $urandom};
            send_flit(d, k == n - 1);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [511:0] make_pk(input logic [CW-1:0] c, input logic [AW-1:0] dst,
                                             input logic [AW-1:0] src, input logic [DW-1:0] dat);
        return {$urandom, $urandom, $urandom, dat, src, dst, c};
    endfunction

    function automatic logic [511:0] rand_pk();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Stimulus: directed sequences and table first, then randomized packets against the packet model
    initial begin
        vec_t          vecs[7];
        logic [511:0]  pk;
        logic [511:0]  pb;
        int            l0;
        int            chg;
        int            errm;
        int            n;
        int            r;
        vecs[0] = '{32'h5, 64'h0012_3400_0000_1000, 64'hAA, 256'hDEAD_BEEF, NF, 1'b1, 8'd0};
        vecs[1] = '{32'h11, 64'h1, 64'h2, 256'h3, 2, 1'b0, 8'd1};
        vecs[2] = '{32'h22, 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, {8{32'hA5A5_5A5A}}, NF, 1'b1, 8'd1};
        vecs[3] = '{32'h33, 64'h4, 64'h5, 256'h6, NF + 2, 1'b0, 8'd2};
        vecs[4] = '{32'hFFFF_FFFF, '1, '1, '1, NF, 1'b1, 8'd2};
        vecs[5] = '{32'h44, 64'h7, 64'h8, 256'h9, 1, 1'b0, 8'd3};
        vecs[6] = '{32'h0, 64'h0, 64'h0, 256'h0, NF, 1'b1, 8'd3};

        rst = 1'b1;
        ready = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_err", err_count, 0);
        tick();

        mon_en = 1'b1;
        pk = make_pk(32'h0000_0005, 64'h0012_3400_0000_1000, 64'hAA, 256'hDEAD_BEEF);
        expq.push_back(pk[TW-1:0]);
        send_pkt(pk, NF, 0);
        @(negedge clk);
        chk("lat_hold_valid", valid, 0);
        chk("lat_hold_in_ready", in_ready, 0);
        @(negedge clk);
        chk("lat_valid", valid, 1);
        chk("lat_cmd", cmd, 32'h0000_0005);
        chk("lat_dst", dstaddr, 64'h0012_3400_0000_1000);
        chk("lat_src", srcaddr, 64'hAA);
        chk("lat_data", data, 256'hDEAD_BEEF);
        tick();
        chk("lat_err", err_count, 0);

        do_reset();
        foreach (vecs[i]) begin
            pk = make_pk(vecs[i].cmd, vecs[i].dst, vecs[i].src, vecs[i].data);
            if (vecs[i].emit) expq.push_back(pk[TW-1:0]);
            send_pkt(pk, vecs[i].nflit, 0);
            repeat (4) tick();
            chk($sformatf("vec%0d_err", i), err_count, vecs[i].err);
            chk($sformatf("vec%0d_drained", i), expq.size(), 0);
        end

        l0 = lowcnt;
        for (int p = 0; p < 3; p++) begin
            pk = rand_pk();
            expq.push_back(pk[TW-1:0]);
            for (int k = 0; k < NF; k++) send_flit(pk[k*FW +: FW], k == NF - 1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("b2b_in_ready_low", lowcnt - l0, 3);
        chk("b2b_drained", expq.size(), 0);

        ready = 1'b0;
        pk = rand_pk();
        pb = rand_pk();
        expq.push_back(pk[TW-1:0]);
        expq.push_back(pb[TW-1:0]);
        send_pkt(pk, NF, 0);
        send_pkt(pb, NF, 0);
        chg = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!valid || {data, srcaddr, dstaddr, cmd} !== pk[TW-1:0]) chg++;
            tick();
        end
        chk("stall_stable", chg, 0);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_valid", valid, 1);
        tick();
        ready = 1'b1;
        tick();
        @(negedge clk);
        chk("stall_second_valid", valid, 1);
        chk("stall_second_data", {data, srcaddr, dstaddr, cmd}, pb[TW-1:0]);
        tick();
        chk("stall_drained", expq.size(), 0);

        ready = 1'b0;
        send_pkt(rand_pk(), NF, 0);
        pk = rand_pk();
        send_flit(pk[FW-1:0], 1'b0);
        send_flit(pk[FW +: FW], 1'b0);
        in_valid = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", valid, 0);
        tick();
        ready = 1'b1;
        pk = rand_pk();
        expq.push_back(pk[TW-1:0]);
        send_pkt(pk, NF, 0);
        repeat (4) tick();
        chk("rst_err", err_count, 0);
        chk("rst_drained", expq.size(), 0);

        for (int i = 0; i < 254; i++) send_pkt(rand_pk(), 1, 0);
        repeat (2) tick();
        chk("sat_254", err_count, 254);
        for (int i = 0; i < 46; i++) send_pkt(rand_pk(), 1, 0);
        repeat (2) tick();
        chk("sat_255", err_count, 255);

        do_reset();
        errm = 0;
        rnd_ready = 1'b1;
        for (int p = 0; p < 80; p++) begin
            r = $urandom_range(9);
            n = r < 6 ? NF : (r < 8 ? $urandom_range(NF - 1, 1) : $urandom_range(NF + 3, NF + 1));
            pk = rand_pk();
            if (n == NF) expq.push_back(pk[TW-1:0]);
            else if (errm < 255) errm++;
            send_pkt(pk, n, 2);
        end
        rnd_ready = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 20 && expq.size() != 0; i++) tick();
        chk("rand_drained", expq.size(), 0);
        chk("rand_err", err_count, errm);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
